// File: rtl/score_meter.sv
// BCD score meter: scaled speed accumulation, milestone flash, session high score.
// Define SCORE_METER_HISCORE_EN to build the high-score register and new_high strobe.
module score_meter #(
    parameter int DIGITS               = 5,
    parameter int SPEED_W              = 15,
    parameter int COEFFICIENT          = 40960,
    parameter int ACHIEVEMENT_DISTANCE = 100,
    parameter int FLASH_DURATION       = 15,
    parameter int FLASH_ITERATIONS     = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  update,
    input  logic                  restart,
    input  logic [SPEED_W-1:0]    speed,
    output logic [4*DIGITS-1:0]   digits,
    output logic [4*DIGITS-1:0]   hi_digits,
    output logic                  paint,
    output logic                  milestone,
    output logic                  new_high
);

    localparam int ACC_W  = $clog2(COEFFICIENT);
    localparam int SUM_W  = ACC_W + 1;
    localparam int MS_W   = $clog2(ACHIEVEMENT_DISTANCE + 1);
    localparam int TMR_W  = $clog2(FLASH_DURATION + 1);
    localparam int ITER_W = $clog2(FLASH_ITERATIONS + 1);
    localparam int BCD_W  = 4 * DIGITS;

    if (COEFFICIENT <= (2 ** SPEED_W) - 1) begin : g_bad_coefficient
        $error("score_meter: COEFFICIENT must exceed the largest speed value");
    end
    if ((DIGITS < 1) || (DIGITS > 8)) begin : g_bad_digits
        $error("score_meter: DIGITS must be within 1..8");
    end

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_FLASH_OFF = 2'd1,
        ST_FLASH_ON  = 2'd2
    } state_t;

    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] v);
        logic [BCD_W-1:0] r;
        logic             carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                carry = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic logic bcd_all9(input logic [BCD_W-1:0] v);
        logic r;
        r = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'd9) begin
                r = 1'b0;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Most significant differing digit decides the comparison
    function automatic logic bcd_gt(input logic [BCD_W-1:0] a, input logic [BCD_W-1:0] b);
        logic gt;
        logic decided;
        gt      = 1'b0;
        decided = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (!decided && (a[4*i +: 4] != b[4*i +: 4])) begin
                gt      = (a[4*i +: 4] > b[4*i +: 4]);
                decided = 1'b1;
            end else begin
                decided = decided;
            end
        end
        return gt;
    endfunction

    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [BCD_W-1:0]  score_q, score_d;
    logic [BCD_W-1:0]  latch_q, latch_d;
    logic [MS_W-1:0]   ms_q, ms_d;
    logic [TMR_W-1:0]  tmr_q, tmr_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    state_t            state_q, state_d;
    logic [BCD_W-1:0]  digits_q, digits_d;
    logic              paint_q, paint_d;
    logic              milestone_q, milestone_d;
    logic [SUM_W-1:0]  sum_s;

`ifdef SCORE_METER_HISCORE_EN
    logic [BCD_W-1:0]  hi_q, hi_d;
    logic              new_high_q, new_high_d;
`endif

    assign sum_s = SUM_W'(acc_q) + SUM_W'(speed);

    // Next-state logic: restart > stopped > update
    always_comb begin
        acc_d       = acc_q;
        score_d     = score_q;
        latch_d     = latch_q;
        ms_d        = ms_q;
        tmr_d       = tmr_q;
        iter_d      = iter_q;
        state_d     = state_q;
        milestone_d = 1'b0;
`ifdef SCORE_METER_HISCORE_EN
        hi_d        = hi_q;
        new_high_d  = 1'b0;
`endif
        if (restart) begin
            acc_d   = {ACC_W{1'b0}};
            score_d = {BCD_W{1'b0}};
            latch_d = {BCD_W{1'b0}};
            ms_d    = {MS_W{1'b0}};
            tmr_d   = {TMR_W{1'b0}};
            iter_d  = {ITER_W{1'b0}};
            state_d = ST_IDLE;
        end else if (speed == {SPEED_W{1'b0}}) begin
`ifdef SCORE_METER_HISCORE_EN
            if (bcd_gt(score_q, hi_q)) begin
                hi_d       = score_q;
                new_high_d = 1'b1;
            end else begin
                hi_d       = hi_q;
            end
`endif
            tmr_d   = {TMR_W{1'b0}};
            iter_d  = {ITER_W{1'b0}};
            state_d = ST_IDLE;
        end else if (update) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_FLASH_OFF: begin
                    if (tmr_q == TMR_W'(FLASH_DURATION - 1)) begin
                        tmr_d   = {TMR_W{1'b0}};
                        state_d = ST_FLASH_ON;
                    end else begin
                        tmr_d   = tmr_q + TMR_W'(1);
                    end
                end
                ST_FLASH_ON: begin
                    if (tmr_q == TMR_W'(FLASH_DURATION - 1)) begin
                        tmr_d = {TMR_W{1'b0}};
                        if (iter_q == ITER_W'(FLASH_ITERATIONS - 1)) begin
                            iter_d  = {ITER_W{1'b0}};
                            state_d = ST_IDLE;
                        end else begin
                            iter_d  = iter_q + ITER_W'(1);
                            state_d = ST_FLASH_OFF;
                        end
                    end else begin
                        tmr_d = tmr_q + TMR_W'(1);
                    end
                end
                default: begin
                    tmr_d   = {TMR_W{1'b0}};
                    iter_d  = {ITER_W{1'b0}};
                    state_d = ST_IDLE;
                end
            endcase

            // A wrap of the accumulator earns one unit, unless the score is saturated
            if (sum_s < SUM_W'(COEFFICIENT)) begin
                acc_d = ACC_W'(sum_s);
            end else begin
                acc_d = ACC_W'(sum_s - SUM_W'(COEFFICIENT));
                if (!bcd_all9(score_q)) begin
                    score_d = bcd_inc(score_q);
                    if (ms_q == MS_W'(ACHIEVEMENT_DISTANCE - 1)) begin
                        ms_d        = {MS_W{1'b0}};
                        milestone_d = 1'b1;
                        latch_d     = bcd_inc(score_q);
                        tmr_d       = {TMR_W{1'b0}};
                        iter_d      = {ITER_W{1'b0}};
                        state_d     = ST_FLASH_OFF;
                    end else begin
                        ms_d = ms_q + MS_W'(1);
                    end
                end else begin
                    score_d = score_q;
                end
            end
        end else begin
            state_d = state_q;
        end

        digits_d = (state_d == ST_IDLE) ? score_d : latch_d;
        paint_d  = (state_d != ST_FLASH_OFF);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= {ACC_W{1'b0}};
            score_q     <= {BCD_W{1'b0}};
            latch_q     <= {BCD_W{1'b0}};
            ms_q        <= {MS_W{1'b0}};
            tmr_q       <= {TMR_W{1'b0}};
            iter_q      <= {ITER_W{1'b0}};
            state_q     <= ST_IDLE;
            digits_q    <= {BCD_W{1'b0}};
            paint_q     <= 1'b1;
            milestone_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            score_q     <= score_d;
            latch_q     <= latch_d;
            ms_q        <= ms_d;
            tmr_q       <= tmr_d;
            iter_q      <= iter_d;
            state_q     <= state_d;
            digits_q    <= digits_d;
            paint_q     <= paint_d;
            milestone_q <= milestone_d;
        end
    end

`ifdef SCORE_METER_HISCORE_EN
    // High-score storage and its replacement strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q       <= {BCD_W{1'b0}};
            new_high_q <= 1'b0;
        end else begin
            hi_q       <= hi_d;
            new_high_q <= new_high_d;
        end
    end

    assign hi_digits = hi_q;
    assign new_high  = new_high_q;
`else
    assign hi_digits = {BCD_W{1'b0}};
    assign new_high  = 1'b0;
`endif

    assign digits    = digits_q;
    assign paint     = paint_q;
    assign milestone = milestone_q;

endmodule

// File: tb/tb_score_meter.sv
// Directed bench for score_meter with small parameters; expectations adapt to SCORE_METER_HISCORE_EN.
module tb_score_meter;

    logic        clk;
    logic        rst_n;
    logic        update;
    logic        restart;
    logic [3:0]  speed;
    logic [11:0] digits;
    logic [11:0] hi_digits;
    logic        paint;
    logic        milestone;
    logic        new_high;

    int total;
    int bad;
    int ms_count;

`ifdef SCORE_METER_HISCORE_EN
    localparam bit HI_EN = 1'b1;
`else
    localparam bit HI_EN = 1'b0;
`endif

    score_meter #(
        .DIGITS(3), .SPEED_W(4), .COEFFICIENT(16),
        .ACHIEVEMENT_DISTANCE(5), .FLASH_DURATION(2), .FLASH_ITERATIONS(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .update(update), .restart(restart), .speed(speed),
        .digits(digits), .hi_digits(hi_digits), .paint(paint),
        .milestone(milestone), .new_high(new_high)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd();
        @(negedge clk);
        update = 1'b1;
        @(posedge clk);
        #1;
        update = 1'b0;
    endtask

    task automatic upd_n(input int n);
        for (int i = 0; i < n; i++) begin
            upd();
            if (milestone === 1'b1) ms_count++;
        end
    endtask

    task automatic do_restart(input logic with_upd);
        @(negedge clk);
        restart = 1'b1;
        update  = with_upd;
        @(posedge clk);
        #1;
        restart = 1'b0;
        update  = 1'b0;
    endtask

    task automatic stop_cycle();
        @(negedge clk);
        speed = 4'd0;
        @(posedge clk);
        #1;
    endtask

    logic exp_paint [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        total = 0; bad = 0; ms_count = 0;
        rst_n = 1'b0; update = 1'b0; restart = 1'b0; speed = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_digits", 32'(digits), 32'h000);
        chk("rst_hi", 32'(hi_digits), 32'h000);
        chk("rst_paint", 32'(paint), 32'd1);
        chk("rst_milestone", 32'(milestone), 32'd0);
        chk("rst_new_high", 32'(new_high), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Speed 8: one unit every second update, milestone on the tenth
        speed = 4'd8;
        for (int k = 1; k <= 10; k++) begin
            upd();
            chk("ms_pulse", 32'(milestone), (k == 10) ? 32'd1 : 32'd0);
        end
        chk("score_005", 32'(digits), 32'h005);
        chk("flash_start_paint", 32'(paint), 32'd0);

        // Flash pattern, display frozen at the latched 005
        for (int k = 0; k < 8; k++) begin
            chk("flash_paint", 32'(paint), 32'(exp_paint[k]));
            chk("flash_digits", 32'(digits), 32'h005);
            upd();
            chk("flash_no_ms", 32'(milestone), 32'd0);
        end
        chk("idle_live_009", 32'(digits), 32'h009);
        chk("idle_paint", 32'(paint), 32'd1);

        // Reach 042 and stop
        do_restart(1'b0);
        chk("restart_digits", 32'(digits), 32'h000);
        chk("restart_paint", 32'(paint), 32'd1);
        ms_count = 0;
        upd_n(84);
        chk("ms_count_42", 32'(ms_count), 32'd8);
        stop_cycle();
        chk("stop42_digits", 32'(digits), 32'h042);
        chk("stop42_paint", 32'(paint), 32'd1);
        chk("stop42_hi", 32'(hi_digits), HI_EN ? 32'h042 : 32'h000);
        chk("stop42_new_high", 32'(new_high), HI_EN ? 32'd1 : 32'd0);
        stop_cycle();
        chk("stop42_pulse_once", 32'(new_high), 32'd0);
        chk("stop42_hi_hold", 32'(hi_digits), HI_EN ? 32'h042 : 32'h000);

        // Lower score does not replace the high score
        do_restart(1'b0);
        speed = 4'd8;
        upd_n(34);
        stop_cycle();
        chk("stop17_digits", 32'(digits), 32'h017);
        chk("stop17_hi", 32'(hi_digits), HI_EN ? 32'h042 : 32'h000);
        chk("stop17_new_high", 32'(new_high), 32'd0);
        stop_cycle();
        chk("stop17_new_high2", 32'(new_high), 32'd0);

        // Restart coincident with update must clear an accumulator holding 14
        do_restart(1'b0);
        speed = 4'd14;
        upd();
        chk("acc14_digits", 32'(digits), 32'h000);
        speed = 4'd15;
        do_restart(1'b1);
        chk("restart_upd_digits", 32'(digits), 32'h000);
        speed = 4'd2;
        upd();
        chk("acc_cleared", 32'(digits), 32'h000);
        speed = 4'd14;
        upd();
        chk("acc_16_inc", 32'(digits), 32'h001);

        // Saturation: 1065 updates at 15 give 998, then pin at 999
        do_restart(1'b0);
        speed = 4'd15;
        upd_n(1065);
        ms_count = 0;
        upd_n(12);
        chk("sat_no_ms", 32'(ms_count), 32'd0);
        chk("sat_999", 32'(digits), 32'h999);
        chk("sat_paint", 32'(paint), 32'd1);
        chk("sat_hi_kept", 32'(hi_digits), HI_EN ? 32'h042 : 32'h000);

        // Asynchronous reset in the middle of a flash
        do_restart(1'b0);
        speed = 4'd8;
        upd_n(10);
        chk("pre_rst_ms", 32'(milestone), 32'd1);
        chk("pre_rst_paint", 32'(paint), 32'd0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_digits", 32'(digits), 32'h000);
        chk("arst_hi", 32'(hi_digits), 32'h000);
        chk("arst_paint", 32'(paint), 32'd1);
        chk("arst_milestone", 32'(milestone), 32'd0);
        chk("arst_new_high", 32'(new_high), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
